// File: rtl/nmr_pkg.sv
// nmr_pkg: shared scheduler state encoding and default field widths.
package nmr_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_ACQ,
        S_REPDLY,
        S_FIN
    } state_t;
    localparam int W_DEF    = 16;
    localparam int TW_DEF   = 32;
    localparam int WDOG_DEF = 1 << 24;
endpackage

// File: rtl/nmr_delay_counter.sv
// nmr_delay_counter: loadable down-counter timing the repetition delay between shots.
module nmr_delay_counter #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          count,
    input  logic [TW-1:0] value,
    output logic          zero
);
    logic [TW-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (load) cnt <= value;
        else if (count && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/nmr_experiment_scheduler.sv
// nmr_experiment_scheduler: sequences NMR shots (pulse, acquire, repetition delay) for navg averages.
// Optional watchdog on PULSE/ACQ enabled by defining NMR_SCHED_WDOG_EN.
module nmr_experiment_scheduler
    import nmr_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int TW          = TW_DEF,
    parameter int WDOG_CYCLES = WDOG_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  cfg_alen,
    input  logic [W-1:0]  cfg_blen,
    input  logic [W-1:0]  cfg_abdly,
    input  logic [W-1:0]  cfg_bbdly,
    input  logic [W-1:0]  cfg_bbcnt,
    input  logic [W-1:0]  cfg_navg,
    input  logic [TW-1:0] cfg_trep,
    output logic [W-1:0]  seq_alen,
    output logic [W-1:0]  seq_blen,
    output logic [W-1:0]  seq_abdly,
    output logic [W-1:0]  seq_bbdly,
    output logic [W-1:0]  seq_bbcnt,
    output logic          seq_rst,
    input  logic          seq_done,
    output logic          acq_trig,
    input  logic          acq_done,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  shot_cnt
);
    state_t        state, nxt;
    logic [W-1:0]  navg_lat;
    logic [TW-1:0] trep_lat;
    logic          dly_zero, dly_load, wd_hit;

    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

`ifdef NMR_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd;
    assign wd_hit = (state == S_PULSE || state == S_ACQ) && wd == WD_W'(WDOG_CYCLES - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd <= (nxt == state && (state == S_PULSE || state == S_ACQ)) ? wd + 1'b1 : '0;
            if (state == S_IDLE && nxt == S_LOAD) err <= 1'b0;
            else if (wd_hit && !abort) err <= 1'b1;
        end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (start && !abort) nxt = S_LOAD;
            S_LOAD:   nxt = cfg_navg == '0 ? S_FIN : S_PULSE;
            S_PULSE:  if (seq_done) nxt = S_ACQ;
            S_ACQ:    if (acq_done) nxt = shot_cnt + 1'b1 == navg_lat ? S_FIN : S_REPDLY;
            S_REPDLY: if (dly_zero) nxt = S_PULSE;
            S_FIN:    nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if ((abort && state != S_IDLE) || wd_hit) nxt = S_IDLE;
    end

    // Loading trep-1 makes REPDLY last trep cycles, and a zero trep still costs one.
    assign dly_load = state == S_ACQ && nxt == S_REPDLY;
    nmr_delay_counter #(.TW(TW)) u_dly (
        .clk   (clk),
        .rst   (rst),
        .load  (dly_load),
        .count (state == S_REPDLY),
        .value (trep_lat == '0 ? '0 : trep_lat - 1'b1),
        .zero  (dly_zero)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            seq_rst   <= 1'b1;
            done      <= 1'b0;
            acq_trig  <= 1'b0;
            shot_cnt  <= '0;
            navg_lat  <= '0;
            trep_lat  <= '0;
            seq_alen  <= '0;
            seq_blen  <= '0;
            seq_abdly <= '0;
            seq_bbdly <= '0;
            seq_bbcnt <= '0;
        end else begin
            state    <= nxt;
            busy     <= nxt != S_IDLE;
            seq_rst  <= nxt != S_PULSE;
            done     <= nxt == S_FIN;
            acq_trig <= state == S_PULSE && nxt == S_ACQ;
            if (state == S_IDLE && nxt == S_LOAD) shot_cnt <= '0;
            if (state == S_ACQ && nxt != S_ACQ && nxt != S_IDLE) shot_cnt <= shot_cnt + 1'b1;
            if (state == S_LOAD) begin
                seq_alen  <= cfg_alen;
                seq_blen  <= cfg_blen;
                seq_abdly <= cfg_abdly;
                seq_bbdly <= cfg_bbdly;
                seq_bbcnt <= cfg_bbcnt;
                navg_lat  <= cfg_navg;
                trep_lat  <= cfg_trep;
            end
        end
endmodule

// File: tb/tb_nmr_experiment_scheduler.sv
// tb_nmr_experiment_scheduler: table-driven and randomized runs checked against cycle arithmetic.
module tb_nmr_experiment_scheduler;
    localparam int W  = 16;
    localparam int TW = 32;

    logic clk = 0, rst = 0, start = 0, abort = 0, seq_done = 0, acq_done = 0;
    logic [W-1:0]  cfg_alen = 0, cfg_blen = 0, cfg_abdly = 0, cfg_bbdly = 0, cfg_bbcnt = 0, cfg_navg = 0;
    logic [TW-1:0] cfg_trep = 0;
    logic [W-1:0]  seq_alen, seq_blen, seq_abdly, seq_bbdly, seq_bbcnt, shot_cnt;
    logic          seq_rst, acq_trig, busy, done, err;

    int errs = 0, checks = 0;
    int pl[8], al[8];
    logic [W-1:0] cfg_exp[5];

    typedef struct {int n; int t; int p; int a; int ab; int shots;} vec_t;
    vec_t tbl[6];

    nmr_experiment_scheduler #(.W(W), .TW(TW), .WDOG_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_alen(cfg_alen), .cfg_blen(cfg_blen), .cfg_abdly(cfg_abdly),
        .cfg_bbdly(cfg_bbdly), .cfg_bbcnt(cfg_bbcnt), .cfg_navg(cfg_navg), .cfg_trep(cfg_trep),
        .seq_alen(seq_alen), .seq_blen(seq_blen), .seq_abdly(seq_abdly),
        .seq_bbdly(seq_bbdly), .seq_bbcnt(seq_bbcnt), .seq_rst(seq_rst),
        .seq_done(seq_done), .acq_trig(acq_trig), .acq_done(acq_done),
        .busy(busy), .done(done), .err(err), .shot_cnt(shot_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] shadow(input int i);
        return i == 0 ? seq_alen : i == 1 ? seq_blen : i == 2 ? seq_abdly : i == 3 ? seq_bbdly : seq_bbcnt;
    endfunction

    task automatic set_cfg(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                           input logic [W-1:0] d, input logic [W-1:0] e);
        cfg_exp[0] = a; cfg_exp[1] = b; cfg_exp[2] = c; cfg_exp[3] = d; cfg_exp[4] = e;
        cfg_alen = a; cfg_blen = b; cfg_abdly = c; cfg_bbdly = d; cfg_bbcnt = e;
    endtask

    task automatic scramble_cfg();
        cfg_alen  = W'($urandom); cfg_blen  = W'($urandom); cfg_abdly = W'($urandom);
        cfg_bbdly = W'($urandom); cfg_bbcnt = W'($urandom); cfg_navg  = W'($urandom);
        cfg_trep  = TW'($urandom);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_seq_rst"}, seq_rst, 1);
        chk({tag, "_acq_trig"}, acq_trig, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_shot_cnt"}, shot_cnt, 0);
        for (int i = 0; i < 5; i++) chk({tag, "_shadow"}, shadow(i), 0);
    endtask

    // A run lasts: start, LOAD, then per shot pulse+acq latency, max(trep,1) between shots, then FIN.
    task automatic run(input int n, input int t, input int ab);
        int cyc = 0, pc = 0, ac = 0, shot = 0, trigs = 0, lowc = 0, psum = 0;
        int done_cyc = -1, dones = 0, gapc = 0, abort_cyc = -1, exp_d;
        bit in_gap = 0, acq_phase = 0;
        @(negedge clk);
        cfg_navg = W'(n);
        cfg_trep = TW'(t);
        start = 1;
        do begin
            @(negedge clk);
            cyc++;
            start = 0; seq_done = 0; acq_done = 0; abort = 0;
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (cyc == 2) begin
                for (int i = 0; i < 5; i++) chk("shadow_after_load", shadow(i), cfg_exp[i]);
                scramble_cfg();
            end
            if (acq_trig) begin
                trigs++;
                acq_phase = 1;
                ac = 0;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (!seq_rst) begin
                if (in_gap) begin
                    chk("repdly_len", gapc, t > 0 ? t : 1);
                    in_gap = 0;
                end
                pc++;
                lowc++;
                if (shot < 8 && pc == pl[shot]) begin
                    seq_done = 1;
                    pc = 0;
                    if (shot + 1 == ab) begin
                        abort = 1;
                        abort_cyc = cyc;
                    end
                end
            end else if (in_gap) gapc++;
            if (acq_phase && shot < 8) begin
                ac++;
                if (ac == al[shot]) begin
                    acq_done = 1;
                    acq_phase = 0;
                    shot++;
                    in_gap = shot < n;
                    gapc = 0;
                end
            end
            if (busy && $urandom_range(0, 7) == 0) start = 1;
        end while ((busy || cyc < 2) && cyc < 5000);
        start = 0; seq_done = 0; acq_done = 0; abort = 0;
        chk("run_finished", cyc < 5000, 1);
        if (ab > 0) begin
            chk("abort_exit_cyc", cyc, abort_cyc + 1);
            chk("abort_acq_trigs", trigs, ab - 1);
            chk("abort_dones", dones, 0);
            chk("abort_shot_cnt", shot_cnt, ab - 1);
        end else begin
            exp_d = 2 + (n > 0 ? (n - 1) * (t > 0 ? t : 1) : 0);
            for (int i = 0; i < n; i++) begin
                exp_d += pl[i] + al[i];
                psum += pl[i];
            end
            chk("done_cycle", done_cyc, exp_d);
            chk("done_count", dones, 1);
            chk("acq_trigs", trigs, n);
            chk("pulse_cycles", lowc, psum);
            chk("shot_cnt", shot_cnt, n);
            chk("idle_cycle", cyc, exp_d + 1);
        end
        repeat (2) @(negedge clk);
        chk("idle_no_done", done | acq_trig | busy, 0);
        chk("shot_cnt_held", shot_cnt, ab > 0 ? ab - 1 : n);
        for (int i = 0; i < 5; i++) chk("shadow_held", shadow(i), cfg_exp[i]);
        chk("err_clear", err, 0);
    endtask

    initial begin
        tbl[0] = '{3, 100, 3, 4, 0, 3};
        tbl[1] = '{0, 7, 1, 1, 0, 0};
        tbl[2] = '{2, 0, 2, 2, 0, 2};
        tbl[3] = '{3, 5, 2, 2, 2, 1};
        tbl[4] = '{1, 1, 1, 1, 0, 1};
        tbl[5] = '{4, 3, 5, 1, 1, 0};

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1;

        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 8; j++) begin
                pl[j] = tbl[k].p;
                al[j] = tbl[k].a;
            end
            if (k == 0) set_cfg(10, 20, 120, 60, 5);
            else set_cfg(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            run(tbl[k].n, tbl[k].t, tbl[k].ab);
            chk("tbl_shots", shot_cnt, tbl[k].shots);
        end

        for (int k = 0; k < 12; k++) begin
            int n, t, ab;
            n = $urandom_range(0, 5);
            t = $urandom_range(0, 12);
            for (int j = 0; j < 8; j++) begin
                pl[j] = $urandom_range(1, 6);
                al[j] = $urandom_range(1, 6);
            end
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            set_cfg(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            run(n, t, ab);
        end

        // Reset pulled in the middle of a repetition delay.
        set_cfg(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        cfg_navg = 2;
        cfg_trep = 50;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 50 && seq_rst; i++) @(negedge clk);
        chk("rst_pulse_reached", seq_rst, 0);
        seq_done = 1;
        @(negedge clk) seq_done = 0;
        chk("rst_acq_trig", acq_trig, 1);
        acq_done = 1;
        @(negedge clk) acq_done = 0;
        repeat (10) @(negedge clk);
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_shots", shot_cnt, 1);
        @(posedge clk);
        #2 rst = 0;
        #1 chk_reset("async_rst");
        @(negedge clk) rst = 1;
        for (int j = 0; j < 8; j++) begin
            pl[j] = 2;
            al[j] = 3;
        end
        set_cfg(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        run(1, 3, 0);

`ifdef NMR_SCHED_WDOG_EN
        begin
            int cyc = 0, lowc = 0, dones = 0;
            cfg_navg = 1;
            cfg_trep = 0;
            @(negedge clk) start = 1;
            do begin
                @(negedge clk);
                start = 0;
                cyc++;
                if (!seq_rst) lowc++;
                if (done) dones++;
            end while ((busy || cyc < 2) && cyc < 3000);
            chk("wdog_pulse_cycles", lowc, 1000);
            chk("wdog_err", err, 1);
            chk("wdog_no_done", dones, 0);
            chk("wdog_idle", busy, 0);
            start = 1;
            @(negedge clk) start = 0;
            chk("wdog_err_cleared", err, 0);
            abort = 1;
            @(negedge clk) abort = 0;
            chk("wdog_abort_idle", busy, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/nmr_experiment_scheduler.md
NMR_EXPERIMENT_SCHEDULER -- requirements
Module: nmr_experiment_scheduler

Interface
REQ-001 SHALL have parameter W, default 16, width of pulse-timing and count fields.
REQ-002 SHALL have parameter TW, default 32, width of repetition-delay field.
REQ-003 SHALL have parameter WDOG_CYCLES, default 2^24, watchdog limit in clocks (used only under NMR_SCHED_WDOG_EN).
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle run request.
REQ-007 SHALL have port abort  in  1  one-cycle run cancel.
REQ-008 SHALL have ports cfg_alen, cfg_blen, cfg_abdly, cfg_bbdly, cfg_bbcnt  in  W each  requested A/B pulse lengths, A-B delay, B-B delay, B count.
REQ-009 SHALL have port cfg_navg  in  W  shots per run.
REQ-010 SHALL have port cfg_trep  in  TW  repetition delay in clocks.
REQ-011 SHALL have ports seq_alen, seq_blen, seq_abdly, seq_bbdly, seq_bbcnt  out  W each  registered shadow values driven to the pulse sequencer.
REQ-012 SHALL have port seq_rst  out  1  active-high hold-in-reset to the pulse sequencer.
REQ-013 SHALL have port seq_done  in  1  one-cycle pulse from the sequencer at end of the last B pulse.
REQ-014 SHALL have port acq_trig  out  1  one-cycle acquisition start.
REQ-015 SHALL have port acq_done  in  1  one-cycle acquisition complete.
REQ-016 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (sticky), shot_cnt  out  W (completed shots).

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, PULSE, ACQ, REPDLY, FIN.
REQ-018 IDLE: start=1 and abort=0 SHALL go to LOAD next cycle and clear shot_cnt and err; start in any other state SHALL be ignored.
REQ-019 LOAD (exactly 1 cycle): SHALL latch all cfg_* into shadows and the navg/trep registers; if latched navg=0 SHALL go to FIN, else PULSE.
REQ-020 seq_rst SHALL be 0 only in PULSE and 1 in every other state; shadows SHALL change only in LOAD.
REQ-021 PULSE: seq_done=1 SHALL assert acq_trig for exactly the following cycle and go to ACQ.
REQ-022 ACQ: acq_done=1 SHALL increment shot_cnt; if new shot_cnt equals navg go to FIN, else load the delay counter with trep and go to REPDLY.
REQ-023 REPDLY SHALL last max(trep,1) cycles, then return to PULSE with unchanged shadows.
REQ-024 FIN SHALL assert done for 1 cycle, then go to IDLE; shot_cnt SHALL hold until next start.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, with no done pulse, no acq_trig, shot_cnt held; abort SHALL win over simultaneous seq_done/acq_done/start.
REQ-027 shot_cnt SHALL never wrap: navg ≤ 2^W−1 by width.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, seq_rst=1, shadows=0, acq_trig=0, done=0, busy=0, err=0, shot_cnt=0, counters=0, including mid-run.

Configuration
REQ-029 NMR_SCHED_WDOG_EN defined: a counter SHALL run in PULSE and ACQ, clearing on state entry; reaching WDOG_CYCLES SHALL set err=1 and go to IDLE without done.
REQ-030 NMR_SCHED_WDOG_EN undefined: no watchdog logic; err SHALL be tied 0; PULSE/ACQ SHALL wait indefinitely.

Structure
REQ-031 State encoding typedef and default widths SHALL live in shared package nmr_pkg.
REQ-032 Repetition-delay down-counter SHALL be sub-module nmr_delay_counter (load, count, zero flag); rest is flat.

Verification
REQ-033 cfg 10/20/120/60/5, navg=3, trep=100, start -> shadows equal cfg 1 cycle after start; 3 acq_trig pulses; REPDLY 100 cycles each; done once; shot_cnt=3.
REQ-034 navg=0, start -> LOAD then FIN; done 2 cycles after start; no acq_trig; seq_rst stays 1.
REQ-035 trep=0, navg=2 -> REPDLY lasts exactly 1 cycle.
REQ-036 abort asserted same cycle as seq_done in shot 2 -> IDLE next cycle, no acq_trig, no done, shot_cnt=1.
REQ-037 rst low mid-REPDLY -> all outputs at reset values immediately; restart with navg=1 completes normally.
REQ-038 With NMR_SCHED_WDOG_EN, WDOG_CYCLES=1000, seq_done never driven -> err=1 after 1000 PULSE cycles, IDLE, no done; next start clears err.
